alu_serial_seq: RTL and testbench
=================================

Name: alu_serial_seq

Overview:
- Bit-serial ALU sequencer. Drives one 1-bit ALU slice (msb_alu) across a WIDTH-bit operand pair, one bit per clock, LSB first.
- Holds operands, carry and result in registers. Resolves SLT/SLTU from the MSB slice after the pass.
- Sits beside the single-cycle datapath as a small-area ALU for multi-cycle/low-power variants. Start/done handshake toward the issuing control logic.

Parameters:
- WIDTH, 32, operand/result width in bits (>=2)
- CW, $clog2(WIDTH), bit-counter width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  request; sampled only in IDLE
- op  in  4  AND=0000 OR=0001 ADD=0010 XOR=0011 SLTU=0101 SUB=0110 SLT=0111
- a  in  WIDTH  operand A, captured on accepted start
- b  in  WIDTH  operand B, captured on accepted start
- busy  out  1  high from the cycle after acceptance until done
- done  out  1  one-cycle completion pulse
- result  out  WIDTH  registered result, held until the next completion
- zero  out  1  result==0, registered with result
- overflow  out  1  signed overflow; ADD/SUB only, else 0
- cout  out  1  MSB carry-out; ADD/SUB/SLT/SLTU, else 0
- err  out  1  illegal op seen; registered with done

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset (async, any state): FSM=IDLE; busy, done, overflow, cout, err=0; result=0; zero=1; counter, carry and shift registers=0.
- FSM states and transitions:
  - IDLE: on start, latch a, b, op. Set carry FF = bneg, where bneg=1 for SUB/SLT/SLTU. Set cnt=0, go to RUN. Illegal op goes straight to DONE with err=1, result=0.
  - RUN: each cycle feed the slice a_sh[0], b_sh[0], bneg, cin=carry FF, less=0, ctrl=op. Shift a_sh and b_sh right. Shift the slice res into result_sh from the MSB side. Carry FF <= slice cout. cnt++.
  - RUN exit: when cnt==WIDTH-1, capture the slice over, set and cout into flag regs. Go to CMP for SLT/SLTU, else to DONE.
  - CMP: result_sh <= {WIDTH-1 zeros, lt}. For SLT, lt = set (MSB sum xor overflow). For SLTU, lt = ~cout (borrow). Go to DONE.
  - DONE: drive result/zero/overflow/cout/err from the work regs. done=1 for exactly one cycle, busy=0. Return to IDLE.
- Latency, start accepted at edge 0:
  - logic/arith: done high in cycle WIDTH+1
  - SLT/SLTU: done high in cycle WIDTH+2
  - illegal op: done high in cycle 1
- busy: 1 in RUN and CMP, 0 in IDLE and DONE.
- start while busy or in DONE: ignored, no queuing. Inputs a/b/op may change freely after acceptance.
- Outputs update only on entering DONE and hold otherwise. overflow/cout are forced 0 for AND/OR/XOR.
- Arithmetic is two's complement modulo 2^WIDTH. SUB is a+~b+1 through the slice's bneg/cin.
- Reset asserted mid-RUN: the operation is aborted, all outputs return to reset values, and no done is produced.
- Back-to-back: start asserted in the cycle after done is accepted, giving one idle gap minimum.

Decomposition:
- Shared package alu_pkg: 4-bit op encodings (ALU_AND, ALU_OR, ALU_ADD, ALU_XOR, ALU_SLTU, ALU_SUB, ALU_SLT), an is_arith/needs_bneg helper, and the FSM state enum (IDLE, RUN, CMP, DONE).
- One sub-module: the existing msb_alu slice, instantiated once. Its set/over outputs are used on the final RUN cycle.
- Counter, carry FF and shift registers stay in alu_serial_seq.

Test Plan (WIDTH=32):
- ADD a=0x7FFFFFFF b=0x00000001 -> done in cycle 33 after start; result=0x80000000, overflow=1, cout=0, zero=0, busy high for 32 cycles.
- SUB a=5 b=7 -> result=0xFFFFFFFE, cout=0, overflow=0. SUB a=7 b=7 -> result=0, zero=1, cout=1.
- SLT a=0xFFFFFFFF b=1 -> result=1, done in cycle 34. SLTU same operands -> result=0. SLTU a=1 b=0xFFFFFFFF -> result=1.
- AND/OR/XOR a=0xF0F0F0F0 b=0xFF00FF00 -> 0xF000F000 / 0xFFF0FFF0 / 0x0FF00FF0; overflow=0, cout=0.
- start pulsed at cycles 5 and 20 during an ADD run -> ignored. Exactly one done. The second op after done completes correctly.
- rst_n low at RUN cycle 10, then start op=0100 -> immediate reset values with no done. The illegal op then gives done in cycle 1, err=1, result=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU op encodings, op-class helpers and the serial sequencer state enum.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLTU = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;

  typedef enum logic [1:0] {IDLE, RUN, CMP, DONE} state_t;

  function automatic logic is_arith(input logic [3:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

  function automatic logic is_cmp(input logic [3:0] op);
    return (op == ALU_SLT) || (op == ALU_SLTU);
  endfunction

  // B is inverted (and carry seeded with 1) for subtract and both compares.
  function automatic logic needs_bneg(input logic [3:0] op);
    return (op == ALU_SUB) || is_cmp(op);
  endfunction

  function automatic logic is_legal(input logic [3:0] op);
    return (op == ALU_AND) || (op == ALU_OR) || (op == ALU_XOR) || is_arith(op) || is_cmp(op);
  endfunction

endpackage

// File: rtl/msb_alu.sv
// One-bit ALU slice with MSB extras: set (sum xor overflow) and signed overflow.
module msb_alu
  import alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       bneg,
  input  logic       cin,
  input  logic       less,
  input  logic [3:0] ctrl,
  output logic       res,
  output logic       cout,
  output logic       set,
  output logic       over
);

  logic bb;
  logic sum;

  assign bb   = b ^ bneg;
  assign sum  = a ^ bb ^ cin;
  assign cout = (a & bb) | (a & cin) | (bb & cin);
  assign over = cin ^ cout;
  assign set  = sum ^ over;

  always_comb begin
    res = 1'b0;
    case (ctrl)
      ALU_AND:  res = a & b;
      ALU_OR:   res = a | b;
      ALU_ADD,
      ALU_SUB:  res = sum;
      ALU_XOR:  res = a ^ b;
      ALU_SLT,
      ALU_SLTU: res = less;
      default:  res = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: walks msb_alu across WIDTH bits LSB first, then resolves SLT/SLTU.
module alu_serial_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             cout,
  output logic             err
);

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_sh_nx;
  logic [3:0]       op_r;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             ovf_f, set_f, cout_f;
  logic             ovf_nx, cout_nx;
  logic             s_res, s_cout, s_set, s_over;
  logic             last, lt, enter_done;

  msb_alu u_slice (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bneg (needs_bneg(op_r)),
    .cin  (carry),
    .less (1'b0),
    .ctrl (op_r),
    .res  (s_res),
    .cout (s_cout),
    .set  (s_set),
    .over (s_over)
  );

  assign last = (cnt == CW'(WIDTH - 1));
  // No borrow out of the MSB means a >= b unsigned.
  assign lt   = (op_r == ALU_SLT) ? set_f : ~cout_f;

  always_comb begin
    state_nx  = state;
    res_sh_nx = res_sh;
    case (state)
      IDLE: begin
        if (start) begin
          if (is_legal(op)) begin
            state_nx = RUN;
          end else begin
            state_nx  = DONE;
            res_sh_nx = '0;
          end
        end
      end
      RUN: begin
        res_sh_nx = {s_res, res_sh[WIDTH-1:1]};
        if (last) state_nx = is_cmp(op_r) ? CMP : DONE;
      end
      CMP: begin
        res_sh_nx = {{(WIDTH-1){1'b0}}, lt};
        state_nx  = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign enter_done = (state_nx == DONE) && (state != DONE);
  assign ovf_nx     = (state == RUN) ? s_over : ovf_f;
  assign cout_nx    = (state == RUN) ? s_cout : cout_f;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      op_r   <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      ovf_f  <= 1'b0;
      set_f  <= 1'b0;
      cout_f <= 1'b0;
    end else begin
      state  <= state_nx;
      res_sh <= res_sh_nx;
      if (state == IDLE && start) begin
        a_sh  <= a;
        b_sh  <= b;
        op_r  <= op;
        carry <= needs_bneg(op);
        cnt   <= '0;
      end else if (state == RUN) begin
        a_sh  <= a_sh >> 1;
        b_sh  <= b_sh >> 1;
        carry <= s_cout;
        cnt   <= cnt + CW'(1);
        if (last) begin
          ovf_f  <= s_over;
          set_f  <= s_set;
          cout_f <= s_cout;
        end
      end
    end
  end

  // Visible outputs change only on the edge that enters DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result   <= '0;
      zero     <= 1'b1;
      overflow <= 1'b0;
      cout     <= 1'b0;
      err      <= 1'b0;
    end else if (enter_done) begin
      result   <= res_sh_nx;
      zero     <= (res_sh_nx == '0);
      if (state == IDLE) begin
        overflow <= 1'b0;
        cout     <= 1'b0;
        err      <= 1'b1;
      end else begin
        overflow <= is_arith(op_r) & ovf_nx;
        cout     <= (is_arith(op_r) | is_cmp(op_r)) & cout_nx;
        err      <= 1'b0;
      end
    end
  end

  assign busy = (state == RUN) || (state == CMP);
  assign done = (state == DONE);

endmodule

// File: tb/tb_alu_serial_seq.sv
// Self-checking bench for alu_serial_seq: directed corner cases plus random ops vs an arithmetic model.
module tb_alu_serial_seq;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [3:0]    op;
  logic [W-1:0]  a, b;
  logic          busy, done, zero, overflow, cout, err;
  logic [W-1:0]  result;

  int n_assert = 0;
  int n_fail   = 0;

  alu_serial_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .zero(zero),
    .overflow(overflow), .cout(cout), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: plain wide arithmetic on the operands.
  task automatic model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       output logic [W-1:0] r, output logic v, output logic c,
                       output logic e, output int lat);
    logic [W:0] s;
    r = '0; v = 1'b0; c = 1'b0; e = 1'b0; lat = W + 1;
    case (o)
      4'b0000: r = x & y;
      4'b0001: r = x | y;
      4'b0011: r = x ^ y;
      4'b0010: begin
        s = {1'b0, x} + {1'b0, y};
        r = s[W-1:0]; c = s[W];
        v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
      end
      4'b0110: begin
        s = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
        r = s[W-1:0]; c = s[W];
        v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
      end
      4'b0111: begin
        r = ($signed(x) < $signed(y)) ? W'(1) : W'(0);
        c = (x >= y); lat = W + 2;
      end
      4'b0101: begin
        r = (x < y) ? W'(1) : W'(0);
        c = (x >= y); lat = W + 2;
      end
      default: begin e = 1'b1; lat = 1; end
    endcase
  endtask

  // Issue one op; optionally pulse start at cycles p1/p2 while it runs.
  task automatic do_op(input string tag, input logic [3:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y, input int p1, input int p2);
    logic [W-1:0] er;
    logic ev, ec, ee, got;
    int lat, cyc, bcnt;
    model(o, x, y, er, ev, ec, ee, lat);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; op = 4'($urandom);
    cyc = 1; bcnt = 0; got = 1'b0;
    while (!got && cyc < 200) begin
      if (done) got = 1'b1;
      else begin
        if (busy) bcnt++;
        start = (cyc == p1 || cyc == p2);
        @(negedge clk);
        start = 1'b0;
        cyc++;
      end
    end
    chk({tag, ".got_done"}, W'(got), W'(1));
    chk({tag, ".latency"}, W'(cyc), W'(lat));
    chk({tag, ".busy_cycles"}, W'(bcnt), W'(lat - 1));
    chk({tag, ".busy_in_done"}, W'(busy), W'(0));
    chk({tag, ".result"}, result, er);
    chk({tag, ".zero"}, W'(zero), W'(er == '0));
    chk({tag, ".overflow"}, W'(overflow), W'(ev));
    chk({tag, ".cout"}, W'(cout), W'(ec));
    chk({tag, ".err"}, W'(err), W'(ee));
    @(negedge clk);
    chk({tag, ".done_one_cycle"}, W'(done), W'(0));
    chk({tag, ".result_held"}, result, er);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".busy"}, W'(busy), W'(0));
    chk({tag, ".done"}, W'(done), W'(0));
    chk({tag, ".result"}, result, W'(0));
    chk({tag, ".zero"}, W'(zero), W'(1));
    chk({tag, ".overflow"}, W'(overflow), W'(0));
    chk({tag, ".cout"}, W'(cout), W'(0));
    chk({tag, ".err"}, W'(err), W'(0));
  endtask

  initial begin
    logic [3:0] ops [7];
    logic [3:0] ro;
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0101, 4'b0110, 4'b0111};
    rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;

    do_op("add_ovf",  4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 0, 0);
    do_op("sub_neg",  4'b0110, 32'd5, 32'd7, 0, 0);
    do_op("sub_zero", 4'b0110, 32'd7, 32'd7, 0, 0);
    do_op("slt",      4'b0111, 32'hFFFF_FFFF, 32'd1, 0, 0);
    do_op("sltu_0",   4'b0101, 32'hFFFF_FFFF, 32'd1, 0, 0);
    do_op("sltu_1",   4'b0101, 32'd1, 32'hFFFF_FFFF, 0, 0);
    do_op("and",      4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 0);
    do_op("or",       4'b0001, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 0);
    do_op("xor",      4'b0011, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 0);
    do_op("add_ign",  4'b0010, 32'h1234_5678, 32'h0FED_CBA9, 5, 20);
    do_op("after_ign", 4'b0110, 32'h8000_0000, 32'd1, 0, 0);

    // Abort a run with reset, then an illegal op.
    @(negedge clk);
    op = 4'b0010; a = 32'hDEAD_BEEF; b = 32'h1111_1111; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("mid_reset");
    repeat (3) begin
      @(negedge clk);
      chk("mid_reset.no_done", W'(done), W'(0));
    end
    rst_n = 1'b1;
    do_op("illegal", 4'b0100, 32'hFFFF_FFFF, 32'h1, 0, 0);
    do_op("legal_after_err", 4'b0000, 32'hFFFF_0000, 32'h0F0F_0F0F, 0, 0);

    for (int i = 0; i < 24; i++) begin
      ro = (i % 8 == 7) ? 4'($urandom_range(8, 15)) : ops[$urandom_range(0, 6)];
      do_op($sformatf("rand%0d", i), ro, $urandom, (i % 5 == 0) ? 32'h8000_0000 : $urandom, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
